uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 57 +++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: circular character buffer between a UART receiver and its consumer, with sticky overflow.
// Define UART_RX_FIFO_FWFT_EN for first-word-fall-through reads; otherwise rd_data is registered (1-cycle latency).
module uart_rx_fifo #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_tick,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 rd_tick,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 empty,
    output logic                 full,
    output logic [ADDR_BITS:0]   count,
    output logic                 overflow,
    input  logic                 overflow_clear
);
    localparam int CW = ADDR_BITS + 1;
    localparam logic [CW-1:0] DEPTH = CW'(2 ** ADDR_BITS);
    logic [DATA_BITS-1:0] mem [2**ADDR_BITS];
    logic [ADDR_BITS-1:0] wr_ptr, rd_ptr;
    logic                 rd_ok, wr_ok, drop;
    logic [CW-1:0]        count_next;
    // A read in the same cycle frees the slot a write into a full buffer needs.
    always_comb begin
        rd_ok      = rd_tick & ~empty;
        wr_ok      = wr_tick & (~full | rd_ok);
        drop       = wr_tick & full & ~rd_tick;
        count_next = count + CW'(wr_ok) - CW'(rd_ok);
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            count    <= count_next;
            empty    <= count_next == '0;
            full     <= count_next == DEPTH;
            overflow <= drop | (overflow & ~overflow_clear);
        end
    always_ff @(posedge clk)
        if (wr_ok) mem[wr_ptr] <= wr_data;
`ifdef UART_RX_FIFO_FWFT_EN
    assign rd_data = empty ? '0 : mem[rd_ptr];
`else
    always_ff @(posedge clk or negedge reset)
        if (!reset) rd_data <= '0;
        else if (rd_ok) rd_data <= mem[rd_ptr];
`endif
endmodule
